// File: rtl/mod13_updown_counter.sv
// Loadable modulo-MODULUS up/down counter with terminal-count and illegal-load
// pulses plus a saturating tally of wraps since reset.
module mod13_updown_counter #(
    parameter int MODULUS = 13,
    parameter int WIDTH   = 4,
    parameter int WRAP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              load_err,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [WIDTH-1:0]  MAX_CNT  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]    MOD_EXT  = (WIDTH + 1)'(MODULUS);
    localparam logic [WRAP_W-1:0] WRAP_SAT = {WRAP_W{1'b1}};

    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             load_err_nxt;
    logic             wrap_hit;
    logic             in_range;

    always_comb begin
        count_nxt    = count;
        tc_nxt       = 1'b0;
        load_err_nxt = 1'b0;
        wrap_hit     = 1'b0;
        in_range     = ({1'b0, count} < MOD_EXT);

        if (load) begin
            if ({1'b0, data_in} < MOD_EXT) begin
                count_nxt = data_in;
            end else begin
                load_err_nxt = 1'b1;
            end
        end else if (!in_range) begin
            // Recover from an unreachable state without claiming a wrap.
            count_nxt = '0;
        end else if (mode) begin
            if (count == MAX_CNT) begin
                count_nxt = '0;
                wrap_hit  = 1'b1;
            end else begin
                count_nxt = count + WIDTH'(1);
            end
        end else begin
            if (count == '0) begin
                count_nxt = MAX_CNT;
                wrap_hit  = 1'b1;
            end else begin
                count_nxt = count - WIDTH'(1);
            end
        end

        tc_nxt = wrap_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            count    <= count_nxt;
            tc       <= tc_nxt;
            load_err <= load_err_nxt;
            if (wrap_hit && (wrap_cnt != WRAP_SAT)) begin
                wrap_cnt <= wrap_cnt + WRAP_W'(1);
            end
        end
    end

endmodule

// File: doc/mod13_updown_counter.md
Name: mod13_updown_counter

Overview:
Loadable mod-13 up/down counter. It is the responder at the far end of the counter stimulus interface. It samples the driven controls (rst, mode, load, data_in) on clk and returns count, which the read monitor samples. It adds status outputs (terminal-count pulse, illegal-load pulse, saturating wrap tally) so that the bench and downstream logic can check wrap and load events without re-deriving them.

Parameters:
MODULUS, 13, number of count states; count range 0..MODULUS-1
WIDTH, 4, width of data_in and count; must satisfy 2**WIDTH >= MODULUS
WRAP_W, 8, width of the saturating wrap tally

Ports:
clk  input  1  single clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset
mode  input  1  direction: 1 = count up, 0 = count down
load  input  1  synchronous parallel load request
data_in  input  WIDTH  load value
count  output  WIDTH  current count, registered
tc  output  1  one-cycle pulse on the cycle count shows a wrapped value
load_err  output  1  one-cycle pulse when a load value is rejected
wrap_cnt  output  WRAP_W  number of wraps since reset, saturating

Behaviour:
- Reset:
  - rst low forces count=0, tc=0, load_err=0, wrap_cnt=0 immediately, without waiting for clk.
  - Outputs hold these values while rst is low.
  - The first update occurs on the first posedge after rst rises.
  - Reset asserted mid-operation (for example during a load) discards that operation with no partial update.
- All outputs are registered. Inputs sampled at posedge N are reflected on the outputs after posedge N; there are no combinational paths from input to output.
- Priority per cycle: load, then count. There is no idle state: with load=0 the counter steps every cycle.
- Load, legal (load=1 and data_in < MODULUS): count<=data_in, tc<=0, load_err<=0, wrap_cnt unchanged.
- Load, illegal (load=1 and data_in >= MODULUS, i.e. 13..15):
  - count holds its value; no step occurs that cycle.
  - load_err<=1 for exactly one cycle; tc<=0.
- Count up (load=0, mode=1):
  - count<=count+1 when count < MODULUS-1.
  - When count == MODULUS-1 (12): count<=0, tc<=1, and wrap_cnt increments.
- Count down (load=0, mode=0):
  - count<=count-1 when count > 0.
  - When count == 0: count<=MODULUS-1 (12), tc<=1, and wrap_cnt increments.
- tc and load_err are pulses. They are cleared on every cycle that does not generate them. They are never asserted together.
- wrap_cnt saturates at 2**WRAP_W-1 and never rolls over. It clears only on reset.
- A direction change takes effect on the next step, with no dead cycle. Example: count=5 with mode toggling 1→0 gives 6, then 5.
- Out-of-range state: count can never hold 13..15. If an illegal state arises through X or upset, the next non-load step forces count<=0 with tc=0 (defensive recovery).
- Width arithmetic: increments and decrements are computed in WIDTH bits. The wrap compare is against MODULUS-1 or 0 only; the design never relies on natural WIDTH overflow.
- The interface timing contract is a setup/hold skew of 1 time unit around posedge clk. Inputs must be stable in that window; the design is fully synchronous apart from rst.

Test Plan:
1. Reset: hold rst=0 across 3 clocks with load=1, data_in=7. Required: count=0, tc=0, load_err=0, wrap_cnt=0 throughout. After rst=1, mode=1, load=0: count goes 1, 2, 3 on successive posedges.
2. Up wrap: load 11, then mode=1 for 3 cycles. Required: count 11→12→0→1. tc=1 only in the cycle count=0. wrap_cnt goes 0→1.
3. Down wrap with direction flip: load 1, then mode=0 for 2 cycles, then mode=1 for 1 cycle. Required: count 1→0→12→0. tc pulses at count=12 and again at count=0. wrap_cnt=2.
4. Illegal load: count=4, load=1 with data_in=13, then data_in=15, then data_in=12. Required: count 4, 4, then 12. load_err pulses for the first two cycles only; tc=0 throughout.
5. Load beats count: count=12, mode=1, load=1, data_in=12. Required: count stays 12, tc=0, wrap_cnt unchanged.
6. Async reset mid-count and saturation:
   - With WRAP_W=2, count up for 60 cycles. Required: wrap_cnt saturates at 3 and tc keeps pulsing every 13 cycles.
   - Drop rst between clock edges. Required: count=0 and wrap_cnt=0 immediately.
